// File: rtl/shift_ctrl_pkg.sv
// Shared constants and types for the shift-load arbiter: state encoding,
// default register width and a grant encoder.
package shift_ctrl_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam int SHIFT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    SHIFT = ST_SHIFT,
    DONE  = ST_DONE
  } state_t;

  function automatic logic [1:0] onehot2(input logic k);
    return k ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/shift_load_arbiter_if.sv
// Request/data/grant bundle between the control logic (master) and the
// shift-load arbiter (slave).
interface shift_load_arbiter_if
  import shift_ctrl_pkg::*;
#(
  parameter int W = SHIFT_W
);

  logic [1:0]   req;
  logic [W-1:0] data0;
  logic [W-1:0] data1;
  logic [1:0]   gnt;
  logic         busy;
  logic         d_out;
  logic [W-1:0] y;
  logic         done;
  logic         done_id;

  modport master (
    output req, data0, data1,
    input  gnt, busy, d_out, y, done, done_id
  );

  modport slave (
    input  req, data0, data1,
    output gnt, busy, d_out, y, done, done_id
  );

endinterface

// File: rtl/shift_load_arbiter_shift_left_n.sv
// W-bit shift-left register: d enters at bit 0 when en is high; clears on
// synchronous reset.
module shift_left_n
  import shift_ctrl_pkg::*;
#(
  parameter int W = SHIFT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         d,
  output logic [W-1:0] y
);

  logic [W-1:0] y_q;
  logic [W-1:0] y_d;

  always_comb begin
    y_d = y_q;
    if (en) begin
      y_d = {y_q[W-2:0], d};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q <= '0;
    end else begin
      y_q <= y_d;
    end
  end

  assign y = y_q;

endmodule

// File: rtl/shift_load_arbiter.sv
// Two-requester arbiter that loads a granted word MSB-first into a shared
// shift-left register. Define SHIFT_LOAD_FIXED_PRIO_EN for fixed priority
// (requester 0 wins ties); default is round-robin.
//
//   state | meaning
//   IDLE  | no transfer; waiting for a request
//   SHIFT | shifting word into y, one bit per cycle for W cycles
//   DONE  | y holds the granted word; done pulse, grant still held
module shift_load_arbiter
  import shift_ctrl_pkg::*;
#(
  parameter int W = SHIFT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  shift_load_arbiter_if.slave  bus
);

  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

  state_t        state_q, state_d;
  logic [1:0]    gnt_q, gnt_d;
  logic [W-1:0]  word_q, word_d;
  logic [CW-1:0] cnt_q, cnt_d;
`ifndef SHIFT_LOAD_FIXED_PRIO_EN
  logic          last_id_q, last_id_d;
`endif

  logic          pick_id;
  logic          d_out;
  logic [W-1:0]  y;

  always_comb begin
    pick_id = 1'b0;
    case (bus.req)
      2'b01:   pick_id = 1'b0;
      2'b10:   pick_id = 1'b1;
`ifdef SHIFT_LOAD_FIXED_PRIO_EN
      2'b11:   pick_id = 1'b0;
`else
      2'b11:   pick_id = ~last_id_q;
`endif
      default: pick_id = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    word_d    = word_q;
    cnt_d     = cnt_q;
`ifndef SHIFT_LOAD_FIXED_PRIO_EN
    last_id_d = last_id_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.req != 2'b00) begin
          word_d  = pick_id ? bus.data1 : bus.data0;
          gnt_d   = onehot2(pick_id);
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d   = IDLE;
        gnt_d     = 2'b00;
`ifndef SHIFT_LOAD_FIXED_PRIO_EN
        last_id_d = gnt_q[1];
`endif
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_q     <= 2'b00;
      word_q    <= '0;
      cnt_q     <= '0;
`ifndef SHIFT_LOAD_FIXED_PRIO_EN
      last_id_q <= 1'b1;
`endif
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      word_q    <= word_d;
      cnt_q     <= cnt_d;
`ifndef SHIFT_LOAD_FIXED_PRIO_EN
      last_id_q <= last_id_d;
`endif
    end
  end

  // MSB first: cnt 0 selects word[W-1]
  assign d_out = (state_q == SHIFT) ? word_q[CNT_LAST - cnt_q] : 1'b0;

  shift_left_n #(.W(W)) u_shift (
    .clk (clk),
    .rst (rst),
    .en  (state_q == SHIFT),
    .d   (d_out),
    .y   (y)
  );

  assign bus.gnt     = gnt_q;
  assign bus.busy    = (state_q == SHIFT) || (state_q == DONE);
  assign bus.d_out   = d_out;
  assign bus.y       = y;
  assign bus.done    = (state_q == DONE);
  assign bus.done_id = gnt_q[1];

endmodule

// File: tb/tb_shift_load_arbiter.sv
// Directed bench for shift_load_arbiter: cycle table for reset and a single
// load, then hand sequences for ties, request drop, mid-shift reset and W=8.
module tb_shift_load_arbiter;

  logic clk;
  logic rst;
  logic rst8;
  int   checks;
  int   failures;

  shift_load_arbiter_if #(.W(4)) bus4 ();
  shift_load_arbiter_if #(.W(8)) bus8 ();

  shift_load_arbiter #(.W(4)) u_dut4 (.clk(clk), .rst(rst),  .bus(bus4));
  shift_load_arbiter #(.W(8)) u_dut8 (.clk(clk), .rst(rst8), .bus(bus8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [1:0] req;
    logic [3:0] d0;
    logic [3:0] d1;
    logic [1:0] gnt;
    logic       busy;
    logic       dout;
    logic [3:0] y;
    logic       done;
    logic       did;
  } vec_t;

  vec_t tbl [9];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic reset4();
    rst = 1'b1;
    bus4.req = 2'b00;
    step();
    rst = 1'b0;
  endtask

  initial begin
    logic [9:0] act_v;
    logic [9:0] exp_v;
    int         done_cyc [3];
    logic       done_ids [3];
    logic [3:0] done_ys  [3];
    int         nd;
    int         guard;
    int         shifts;
    logic [7:0] bits;
    logic       exp_id;
    logic [3:0] exp_y;

    checks = 0;
    failures = 0;
    rst = 1'b1;
    rst8 = 1'b1;
    bus4.req = 2'b11;
    bus4.data0 = 4'h0;
    bus4.data1 = 4'h0;
    bus8.req = 2'b00;
    bus8.data0 = 8'h00;
    bus8.data1 = 8'h00;

    //          rst  req    d0      d1      gnt    busy dout y       done did
    tbl[0] = '{1'b1, 2'b11, 4'hB, 4'h0, 2'b00, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 2'b11, 4'hB, 4'h0, 2'b00, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 2'b01, 4'hB, 4'h0, 2'b01, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 2'b01, 4'h0, 4'h0, 2'b01, 1'b1, 1'b0, 4'b0001, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 2'b01, 4'h0, 4'h0, 2'b01, 1'b1, 1'b1, 4'b0010, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 2'b01, 4'h0, 4'h0, 2'b01, 1'b1, 1'b1, 4'b0101, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 2'b00, 4'h0, 4'h0, 2'b01, 1'b1, 1'b0, 4'b1011, 1'b1, 1'b0};
    tbl[7] = '{1'b0, 2'b00, 4'h0, 4'h0, 2'b00, 1'b0, 1'b0, 4'b1011, 1'b0, 1'b0};
    tbl[8] = '{1'b0, 2'b00, 4'h0, 4'h0, 2'b00, 1'b0, 1'b0, 4'b1011, 1'b0, 1'b0};

    for (int i = 0; i < 9; i++) begin
      rst        = tbl[i].rst;
      bus4.req   = tbl[i].req;
      bus4.data0 = tbl[i].d0;
      bus4.data1 = tbl[i].d1;
      step();
      act_v = {bus4.gnt, bus4.busy, bus4.d_out, bus4.y, bus4.done,
               bus4.done ? bus4.done_id : 1'b0};
      exp_v = {tbl[i].gnt, tbl[i].busy, tbl[i].dout, tbl[i].y, tbl[i].done, tbl[i].did};
      chk($sformatf("table_row%0d", i), 32'(act_v), 32'(exp_v));
    end

    // Tie: both requesting with words held
    reset4();
    bus4.req = 2'b11;
    bus4.data0 = 4'b1100;
    bus4.data1 = 4'b0011;
    nd = 0;
    for (int c = 0; c < 30 && nd < 3; c++) begin
      step();
      if (bus4.done) begin
        done_cyc[nd] = c;
        done_ids[nd] = bus4.done_id;
        done_ys[nd]  = bus4.y;
        nd++;
      end
    end
    chk("tie_done_count", 32'(nd), 32'd3);
    for (int k = 0; k < nd; k++) begin
`ifdef SHIFT_LOAD_FIXED_PRIO_EN
      exp_id = 1'b0;
`else
      exp_id = (k == 1);
`endif
      exp_y = exp_id ? 4'b0011 : 4'b1100;
      chk($sformatf("tie_done_id%0d", k), 32'(done_ids[k]), 32'(exp_id));
      chk($sformatf("tie_y%0d", k), 32'(done_ys[k]), 32'(exp_y));
      if (k > 0) chk($sformatf("tie_period%0d", k), 32'(done_cyc[k] - done_cyc[k-1]), 32'd6);
    end

    // Request dropped and data changed after two shift cycles
    reset4();
    bus4.req = 2'b10;
    bus4.data1 = 4'b0110;
    step();
    step();
    step();
    bus4.req = 2'b00;
    bus4.data1 = 4'b1111;
    guard = 0;
    while (!bus4.done && guard < 10) begin
      step();
      guard++;
    end
    chk("drop_done_seen", 32'(bus4.done), 32'd1);
    chk("drop_y", 32'(bus4.y), 32'b0110);
    chk("drop_done_id", 32'(bus4.done_id), 32'd1);
    chk("drop_gnt", 32'(bus4.gnt), 32'b10);

    // Reset during the third shift cycle discards the transfer
    reset4();
    bus4.req = 2'b01;
    bus4.data0 = 4'b1001;
    step();
    bus4.req = 2'b00;
    step();
    step();
    chk("mid_busy_before_rst", 32'(bus4.busy), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_gnt", 32'(bus4.gnt), 32'b00);
    chk("mid_busy", 32'(bus4.busy), 32'd0);
    chk("mid_y", 32'(bus4.y), 32'b0000);
    chk("mid_dout", 32'(bus4.d_out), 32'd0);
    nd = 0;
    for (int c = 0; c < 12; c++) begin
      step();
      if (bus4.done) nd++;
    end
    chk("mid_no_done", 32'(nd), 32'd0);

    // Width 8 instance
    rst8 = 1'b1;
    step();
    rst8 = 1'b0;
    bus8.req = 2'b01;
    bus8.data0 = 8'hA5;
    step();
    bus8.req = 2'b00;
    bus8.data0 = 8'h00;
    shifts = 0;
    bits = 8'h00;
    guard = 0;
    while (!bus8.done && guard < 20) begin
      if (bus8.busy) begin
        shifts++;
        bits = {bits[6:0], bus8.d_out};
      end
      step();
      guard++;
    end
    chk("w8_done", 32'(bus8.done), 32'd1);
    chk("w8_shift_cycles", 32'(shifts), 32'd8);
    chk("w8_dout_bits", 32'(bits), 32'hA5);
    chk("w8_y", 32'(bus8.y), 32'hA5);
    chk("w8_done_id", 32'(bus8.done_id), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
